// File: rtl/scalar_operand_collector.sv
// rtl/scalar_operand_collector.sv - single-entry scalar operand collector
// Requests up to two SGPR operands from banked ports, snoops writeback in the grant cycle.
module scalar_operand_collector #(
  parameter int XLEN          = 32,
  parameter int DEPTH_REGBANK = 8,
  parameter int BANK_W        = 2,
  parameter int TAG_W         = 8,
  localparam int IDX_W        = BANK_W + DEPTH_REGBANK
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [TAG_W-1:0]         in_tag,
  input  logic                     in_rs1_en,
  input  logic                     in_rs2_en,
  input  logic [IDX_W-1:0]         in_rs1_idx,
  input  logic [IDX_W-1:0]         in_rs2_idx,
  output logic                     rd1_req_valid,
  output logic [BANK_W-1:0]        rd1_req_bank,
  output logic [DEPTH_REGBANK-1:0] rd1_req_row,
  input  logic                     rd1_grant,
  input  logic [XLEN-1:0]          rd1_rdata,
  output logic                     rd2_req_valid,
  output logic [BANK_W-1:0]        rd2_req_bank,
  output logic [DEPTH_REGBANK-1:0] rd2_req_row,
  input  logic                     rd2_grant,
  input  logic [XLEN-1:0]          rd2_rdata,
  input  logic                     wb_valid,
  input  logic [IDX_W-1:0]         wb_idx,
  input  logic [XLEN-1:0]          wb_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [TAG_W-1:0]         out_tag,
  output logic [XLEN-1:0]          out_rs1,
  output logic [XLEN-1:0]          out_rs2
);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_OUT} state_e;

  state_e            state_q, state_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [IDX_W-1:0]  idx1_q, idx1_d, idx2_q, idx2_d;
  logic              pend1_q, pend1_d, pend2_q, pend2_d;
  logic              infl1_q, infl1_d, infl2_q, infl2_d;
  logic              fwd1_q, fwd1_d, fwd2_q, fwd2_d;
  logic [XLEN-1:0]   op1_q, op1_d, op2_q, op2_d;
  logic              out_valid_q, out_valid_d;
  logic              grant1, grant2;

  assign in_ready      = (state_q == S_IDLE) & ~rst;
  assign rd1_req_valid = (state_q == S_COLLECT) & pend1_q & ~infl1_q;
  assign rd2_req_valid = (state_q == S_COLLECT) & pend2_q & ~infl2_q;
  assign rd1_req_bank  = idx1_q[BANK_W-1:0];
  assign rd1_req_row   = idx1_q[IDX_W-1:BANK_W];
  assign rd2_req_bank  = idx2_q[BANK_W-1:0];
  assign rd2_req_row   = idx2_q[IDX_W-1:BANK_W];
  assign grant1        = rd1_req_valid & rd1_grant;
  assign grant2        = rd2_req_valid & rd2_grant;
  assign out_valid     = out_valid_q;
  assign out_tag       = tag_q;
  assign out_rs1       = op1_q;
  assign out_rs2       = op2_q;

  always_comb begin
    state_d     = state_q;
    tag_d       = tag_q;
    idx1_d      = idx1_q;
    idx2_d      = idx2_q;
    pend1_d     = pend1_q;
    pend2_d     = pend2_q;
    infl1_d     = infl1_q;
    infl2_d     = infl2_q;
    fwd1_d      = fwd1_q;
    fwd2_d      = fwd2_q;
    op1_d       = op1_q;
    op2_d       = op2_q;
    out_valid_d = out_valid_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          tag_d   = in_tag;
          idx1_d  = in_rs1_idx;
          idx2_d  = in_rs2_idx;
          pend1_d = in_rs1_en;
          pend2_d = in_rs2_en;
          infl1_d = 1'b0;
          infl2_d = 1'b0;
          fwd1_d  = 1'b0;
          fwd2_d  = 1'b0;
          op1_d   = '0;
          op2_d   = '0;
          state_d = S_COLLECT;
        end
      end
      S_COLLECT: begin
        // A forwarded writeback already sits in op_k, so the stale bank read is dropped.
        if (infl1_q) begin
          infl1_d = 1'b0;
          fwd1_d  = 1'b0;
          if (!fwd1_q) op1_d = rd1_rdata;
        end
        if (infl2_q) begin
          infl2_d = 1'b0;
          fwd2_d  = 1'b0;
          if (!fwd2_q) op2_d = rd2_rdata;
        end
        if (grant1) begin
          pend1_d = 1'b0;
          infl1_d = 1'b1;
          if (wb_valid && (wb_idx == idx1_q)) begin
            fwd1_d = 1'b1;
            op1_d  = wb_data;
          end
        end
        if (grant2) begin
          pend2_d = 1'b0;
          infl2_d = 1'b1;
          if (wb_valid && (wb_idx == idx2_q)) begin
            fwd2_d = 1'b1;
            op2_d  = wb_data;
          end
        end
        if (!(pend1_d | pend2_d | infl1_d | infl2_d)) begin
          state_d     = S_OUT;
          out_valid_d = 1'b1;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      tag_q       <= '0;
      idx1_q      <= '0;
      idx2_q      <= '0;
      pend1_q     <= 1'b0;
      pend2_q     <= 1'b0;
      infl1_q     <= 1'b0;
      infl2_q     <= 1'b0;
      fwd1_q      <= 1'b0;
      fwd2_q      <= 1'b0;
      op1_q       <= '0;
      op2_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tag_q       <= tag_d;
      idx1_q      <= idx1_d;
      idx2_q      <= idx2_d;
      pend1_q     <= pend1_d;
      pend2_q     <= pend2_d;
      infl1_q     <= infl1_d;
      infl2_q     <= infl2_d;
      fwd1_q      <= fwd1_d;
      fwd2_q      <= fwd2_d;
      op1_q       <= op1_d;
      op2_q       <= op2_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_scalar_operand_collector.sv
// tb/tb_scalar_operand_collector.sv - directed vector bench for scalar_operand_collector
module tb_scalar_operand_collector;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [7:0]  in_tag;
  logic        in_rs1_en, in_rs2_en;
  logic [9:0]  in_rs1_idx, in_rs2_idx;
  logic        rd1_req_valid, rd2_req_valid;
  logic [1:0]  rd1_req_bank, rd2_req_bank;
  logic [7:0]  rd1_req_row, rd2_req_row;
  logic        rd1_grant, rd2_grant;
  logic [31:0] rd1_rdata, rd2_rdata;
  logic        wb_valid;
  logic [9:0]  wb_idx;
  logic [31:0] wb_data;
  logic        out_valid, out_ready;
  logic [7:0]  out_tag;
  logic [31:0] out_rs1, out_rs2;

  int n_vec = 0;
  int n_err = 0;

  scalar_operand_collector dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_tag(in_tag),
    .in_rs1_en(in_rs1_en), .in_rs2_en(in_rs2_en),
    .in_rs1_idx(in_rs1_idx), .in_rs2_idx(in_rs2_idx),
    .rd1_req_valid(rd1_req_valid), .rd1_req_bank(rd1_req_bank), .rd1_req_row(rd1_req_row),
    .rd1_grant(rd1_grant), .rd1_rdata(rd1_rdata),
    .rd2_req_valid(rd2_req_valid), .rd2_req_bank(rd2_req_bank), .rd2_req_row(rd2_req_row),
    .rd2_grant(rd2_grant), .rd2_rdata(rd2_rdata),
    .wb_valid(wb_valid), .wb_idx(wb_idx), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag),
    .out_rs1(out_rs1), .out_rs2(out_rs2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  tag;
    logic        en1, en2;
    logic [9:0]  idx1, idx2;
    int          g1, g2;
    logic [31:0] rd1, rd2;
    int          wb_cyc;
    logic [9:0]  wbi;
    logic [31:0] wbd;
    logic [31:0] exp1, exp2;
    int          exp_cyc;
  } vec_t;

  vec_t vecs[11];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    in_valid = 0; in_tag = 8'h00; in_rs1_en = 0; in_rs2_en = 0;
    in_rs1_idx = 10'h0; in_rs2_idx = 10'h0;
    rd1_grant = 0; rd2_grant = 0; rd1_rdata = 32'h0; rd2_rdata = 32'h0;
    wb_valid = 0; wb_idx = 10'h0; wb_data = 32'h0;
  endtask

  // Cycle 1 is the first cycle after the accept edge; grant k lands in cycle 1+g_k, data in 2+g_k.
  task automatic run_vec(input vec_t v, input int id);
    int c;
    int first;
    int bad;
    logic exp_r1, exp_r2;
    chk($sformatf("v%0d in_ready", id), in_ready, 1'b1);
    in_valid = 1; in_tag = v.tag; in_rs1_en = v.en1; in_rs2_en = v.en2;
    in_rs1_idx = v.idx1; in_rs2_idx = v.idx2;
    out_ready = 1;
    step();
    in_valid = 0; in_tag = ~v.tag; in_rs1_en = 1; in_rs2_en = 1;
    in_rs1_idx = ~v.idx1; in_rs2_idx = ~v.idx2;
    first = 0;
    bad = 0;
    c = 1;
    while (c <= 40 && first == 0) begin
      exp_r1 = v.en1 && (c <= 1 + v.g1);
      exp_r2 = v.en2 && (c <= 1 + v.g2);
      if (rd1_req_valid !== exp_r1) bad++;
      if (rd2_req_valid !== exp_r2) bad++;
      if (rd1_req_valid === 1'b1 && (rd1_req_bank !== v.idx1[1:0] || rd1_req_row !== v.idx1[9:2])) bad++;
      if (rd2_req_valid === 1'b1 && (rd2_req_bank !== v.idx2[1:0] || rd2_req_row !== v.idx2[9:2])) bad++;
      if (out_valid === 1'b1) begin
        first = c;
        chk($sformatf("v%0d out_tag", id), out_tag, v.tag);
        chk($sformatf("v%0d out_rs1", id), out_rs1, v.exp1);
        chk($sformatf("v%0d out_rs2", id), out_rs2, v.exp2);
      end
      rd1_grant = (c == 1 + v.g1);
      rd2_grant = (c == 1 + v.g2);
      rd1_rdata = (c == 2 + v.g1) ? v.rd1 : (32'hBAD10000 | 32'(c));
      rd2_rdata = (c == 2 + v.g2) ? v.rd2 : (32'hBAD20000 | 32'(c));
      wb_valid  = (c == v.wb_cyc);
      wb_idx    = v.wbi;
      wb_data   = v.wbd;
      step();
      c++;
    end
    idle_inputs();
    chk($sformatf("v%0d out_valid cycle", id), first, v.exp_cyc);
    chk($sformatf("v%0d req pattern errors", id), bad, 0);
    chk($sformatf("v%0d out_valid after handshake", id), out_valid, 1'b0);
  endtask

  initial begin
    int stall_bad;
    int seen;
    idle_inputs();
    out_ready = 1;
    rst = 1;

    //            tag    e1 e2 idx1    idx2    g1 g2 rd1           rd2           wbc wbi     wbd           exp1          exp2          cyc
    vecs[0]  = '{8'h3C, 1, 1, 10'h005, 10'h00A, 0, 0, 32'h11111111, 32'h22222222, 0, 10'h000, 32'h0,        32'h11111111, 32'h22222222, 3};
    vecs[1]  = '{8'h41, 1, 1, 10'h123, 10'h3FF, 0, 4, 32'hA0A00001, 32'hB0B00002, 0, 10'h000, 32'h0,        32'hA0A00001, 32'hB0B00002, 7};
    vecs[2]  = '{8'h52, 1, 1, 10'h0C4, 10'h010, 0, 0, 32'h00000000, 32'h5555AAAA, 1, 10'h0C4, 32'hDEADBEEF, 32'hDEADBEEF, 32'h5555AAAA, 3};
    vecs[3]  = '{8'h53, 1, 1, 10'h0C4, 10'h010, 0, 0, 32'h00000000, 32'h5555AAAA, 2, 10'h0C4, 32'hDEADBEEF, 32'h00000000, 32'h5555AAAA, 3};
    vecs[4]  = '{8'h64, 0, 0, 10'h001, 10'h002, 0, 0, 32'hCAFE0001, 32'hCAFE0002, 0, 10'h000, 32'h0,        32'h00000000, 32'h00000000, 2};
    vecs[5]  = '{8'h75, 1, 0, 10'h2A1, 10'h002, 2, 0, 32'h0F0F0F0F, 32'hCAFE0002, 0, 10'h000, 32'h0,        32'h0F0F0F0F, 32'h00000000, 5};
    vecs[6]  = '{8'h86, 0, 1, 10'h001, 10'h1C3, 0, 1, 32'hCAFE0001, 32'h76543210, 0, 10'h000, 32'h0,        32'h00000000, 32'h76543210, 4};
    vecs[7]  = '{8'h97, 1, 1, 10'h0FE, 10'h301, 3, 0, 32'h89ABCDEF, 32'h01234567, 0, 10'h000, 32'h0,        32'h89ABCDEF, 32'h01234567, 6};
    vecs[8]  = '{8'hA8, 1, 1, 10'h2B7, 10'h2B7, 0, 0, 32'h31313131, 32'h32323232, 0, 10'h000, 32'h0,        32'h31313131, 32'h32323232, 3};
    vecs[9]  = '{8'hB9, 1, 1, 10'h033, 10'h144, 0, 1, 32'h44440001, 32'h44440002, 2, 10'h144, 32'hFEEDF00D, 32'h44440001, 32'hFEEDF00D, 4};
    vecs[10] = '{8'hCA, 1, 1, 10'h033, 10'h144, 0, 0, 32'h55550001, 32'h55550002, 1, 10'h145, 32'hFEEDF00D, 32'h55550001, 32'h55550002, 3};

    step();
    step();
    chk("reset in_ready", in_ready, 1'b0);
    chk("reset out_valid", out_valid, 1'b0);
    chk("reset rd1_req_valid", rd1_req_valid, 1'b0);
    chk("reset rd2_req_valid", rd2_req_valid, 1'b0);
    chk("reset out_tag", out_tag, 8'h00);
    chk("reset out_rs1", out_rs1, 32'h0);
    chk("reset out_rs2", out_rs2, 32'h0);
    rst = 0;
    #1;
    chk("post-reset in_ready", in_ready, 1'b1);
    step();

    for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

    // Output backpressure: results held, new instruction refused until the handshake.
    out_ready = 0;
    in_valid = 1; in_tag = 8'h77; in_rs1_en = 1; in_rs2_en = 1;
    in_rs1_idx = 10'h001; in_rs2_idx = 10'h002;
    step();
    in_tag = 8'h99; in_rs1_en = 0; in_rs2_en = 0;
    rd1_grant = 1; rd2_grant = 1;
    step();
    rd1_grant = 0; rd2_grant = 0;
    rd1_rdata = 32'h13579BDF; rd2_rdata = 32'h2468ACE0;
    step();
    rd1_rdata = 32'h0; rd2_rdata = 32'h0;
    chk("bp out_valid", out_valid, 1'b1);
    stall_bad = 0;
    for (int k = 0; k < 5; k++) begin
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_tag !== 8'h77 ||
          out_rs1 !== 32'h13579BDF || out_rs2 !== 32'h2468ACE0) stall_bad++;
      step();
    end
    chk("bp stall cycles with changed outputs", stall_bad, 0);
    chk("bp rs1 held", out_rs1, 32'h13579BDF);
    out_ready = 1;
    step();
    chk("bp out_valid after handshake", out_valid, 1'b0);
    chk("bp in_ready after handshake", in_ready, 1'b1);
    step();
    in_valid = 0;
    chk("bp second instr out_valid c1", out_valid, 1'b0);
    step();
    chk("bp second instr out_valid c2", out_valid, 1'b1);
    chk("bp second instr tag", out_tag, 8'h99);
    chk("bp second instr rs1", out_rs1, 32'h0);
    step();
    idle_inputs();

    // Reset in the cycle after the rd1 grant: in-flight data and late data both dropped.
    in_valid = 1; in_tag = 8'hE1; in_rs1_en = 1; in_rs2_en = 1;
    in_rs1_idx = 10'h00D; in_rs2_idx = 10'h00E;
    step();
    in_valid = 0;
    rd1_grant = 1;
    step();
    rd1_grant = 0;
    rd1_rdata = 32'h66666666;
    rst = 1;
    step();
    rd1_rdata = 32'h77777777;
    chk("rst out_valid", out_valid, 1'b0);
    chk("rst rd1_req_valid", rd1_req_valid, 1'b0);
    chk("rst rd2_req_valid", rd2_req_valid, 1'b0);
    chk("rst in_ready", in_ready, 1'b0);
    chk("rst out_rs1", out_rs1, 32'h0);
    chk("rst out_tag", out_tag, 8'h00);
    step();
    rst = 0;
    #1;
    chk("after rst in_ready", in_ready, 1'b1);
    step();
    rd1_rdata = 32'h0;
    chk("after rst out_valid", out_valid, 1'b0);
    chk("after rst out_rs1", out_rs1, 32'h0);
    seen = rd1_req_valid | rd2_req_valid;
    chk("after rst no stale req", seen, 0);

    run_vec(vecs[0], 11);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/scalar_operand_collector.md
SCALAR_OPERAND_COLLECTOR -- requirements
Module: scalar_operand_collector

Interface
REQ-001 SHALL have parameter XLEN, default 32, scalar data width.
REQ-002 SHALL have parameter DEPTH_REGBANK, default 8, bank row-address width.
REQ-003 SHALL have parameter BANK_W, default 2, bank-select width (4 banks).
REQ-004 SHALL have parameter TAG_W, default 8, opaque instruction tag width; IDX_W = BANK_W+DEPTH_REGBANK.
REQ-005 SHALL have port clk  in  1  sole clock, rising edge.
REQ-006 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-007 SHALL have ports in_valid in 1 / in_ready out 1  instruction handshake.
REQ-008 SHALL have ports in_tag in TAG_W; in_rs1_en, in_rs2_en in 1; in_rs1_idx, in_rs2_idx in IDX_W  global SGPR index, bank=idx[BANK_W-1:0], row=idx[IDX_W-1:BANK_W].
REQ-009 SHALL have, per operand k in {1,2}: rdk_req_valid out 1; rdk_req_bank out BANK_W; rdk_req_row out DEPTH_REGBANK; rdk_grant in 1; rdk_rdata in XLEN (bank rs_o, valid cycle after grant).
REQ-010 SHALL have ports wb_valid in 1, wb_idx in IDX_W, wb_data in XLEN  scalar writeback snoop.
REQ-011 SHALL have ports out_valid out 1 / out_ready in 1; out_tag out TAG_W; out_rs1, out_rs2 out XLEN.

Function
REQ-012 SHALL implement FSM IDLE, COLLECT, OUT; in_ready = (state==IDLE) & ~rst.
REQ-013 SHALL, on in_valid&in_ready, latch tag/indices/enables, set pend_k=in_rsk_en, clear operand regs, enter COLLECT.
REQ-014 SHALL drive rdk_req_valid = (state==COLLECT) & pend_k & ~infl_k; bank/row from latched index, stable while valid.
REQ-015 SHALL, on rdk_req_valid&rdk_grant, clear pend_k, set infl_k for exactly one cycle; grant without req_valid SHALL be ignored.
REQ-016 SHALL, in cycle with infl_k, capture rdk_rdata into operand k and clear infl_k.
REQ-017 SHALL, if wb_valid & wb_idx==latched idx_k in the grant cycle of k, record forward flag and capture wb_data instead of rdk_rdata next cycle (bank has no write-read bypass).
REQ-018 SHALL ignore wb in any other cycle (scoreboard guarantees ordering).
REQ-019 SHALL leave disabled operand as zero and treat it as already collected.
REQ-020 SHALL go COLLECT->OUT at the edge where no pend_k and no infl_k remain after that cycle's captures.
REQ-021 SHALL assert out_valid only in OUT; out_* held stable until out_valid&out_ready, then -> IDLE.
REQ-022 SHALL, with both operands enabled and grants in first COLLECT cycle, raise out_valid 3 cycles after accept edge; both disabled: 2 cycles.
REQ-023 SHALL permit grants for operands in different cycles in either order; operand 1 and 2 with same index SHALL issue two independent requests.
REQ-024 SHALL accept no new instruction until OUT handshake completes (single-entry).

Reset
REQ-025 SHALL, while rst high at an edge, set state IDLE, pend/infl/forward flags 0, out_tag/out_rs1/out_rs2 0; out_valid, rdk_req_valid, in_ready 0.
REQ-026 SHALL abort any in-progress collection on reset; rdata arriving the cycle after reset SHALL be discarded.

Verification
REQ-027 Accept idx1=0x005, idx2=0x00A, grants immediate, rdata 0x11111111/0x22222222 -> out_valid 3 cycles post-accept, out_rs1=0x11111111, out_rs2=0x22222222, bank1=1,row1=1, bank2=2,row2=2.
REQ-028 Grant rd1 cycle 1, rd2 stalled 4 cycles -> rd2_req_valid held with constant bank/row, out_valid one cycle after rd2 capture, rs1 value retained.
REQ-029 wb_valid, wb_idx=idx1, wb_data=0xDEADBEEF in rd1 grant cycle, rd1_rdata=0x0 -> out_rs1=0xDEADBEEF; same wb one cycle later -> out_rs1=0x0.
REQ-030 in_rs1_en=0, in_rs2_en=0 -> no req_valid, out_valid 2 cycles post-accept, out_rs1=out_rs2=0.
REQ-031 out_ready low 5 cycles -> out_* stable, in_ready=0, second in_valid not accepted until handshake.
REQ-032 rst asserted in cycle after rd1 grant -> next cycle out_valid=0, req_valid=0, in_ready=0; after deassert in_ready=1, no stale output.
